wrap_counter: RTL and testbench

- Enable-gated up-counter with a run-time programmable terminal value `max`.
- Counts 0..max on each enabled clock, then wraps to 0.
- Flags terminal count with a level output (`top`) and a single-cycle rising-edge strobe (`top_pulse`).
- Used as a generic prescaler/timebase building block, e.g. for baud/tick generation and timers.

---
 rtl/wrap_counter.sv | 25 ++
 tb/tb_wrap_counter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/wrap_counter.sv
// wrap_counter: enable-gated up-counter 0..max with level (top) and rising-edge strobe (top_pulse); ports clk, reset (sync, active-low), en, max, top, top_pulse, val
module wrap_counter #(
    parameter int COUNTER_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [COUNTER_WIDTH-1:0] max,
    output logic                     top,
    output logic                     top_pulse,
    output logic [COUNTER_WIDTH-1:0] val
);
    logic top_q;
    always_ff @(posedge clk) begin
        if (!reset) begin
            val   <= '0;
            top_q <= 1'b0;
        end else begin
            top_q <= top;
            if (en) val <= (val >= max) ? '0 : val + 1'b1;
        end
    end
    assign top       = (val == max);
    assign top_pulse = top & ~top_q & reset;
endmodule

// File: tb/tb_wrap_counter.sv
// tb_wrap_counter: directed self-checking bench for wrap_counter
module tb_wrap_counter;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic [3:0] max = 4'd7;
    logic       top;
    logic       top_pulse;
    logic [3:0] val;
    int         n_cmp = 0;
    int         n_bad = 0;

    wrap_counter #(.COUNTER_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .en(en), .max(max),
        .top(top), .top_pulse(top_pulse), .val(val)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        max = 4'd7; en = 1'b1; reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({val, top, top_pulse} !== {4'd0, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL reset_hold cyc%0d: val=%0d top=%b pulse=%b, required val=0 top=0 pulse=0", i, val, top, top_pulse);
            end
        end
        en = 1'b0; reset = 1'b1;
        tick();
        n_cmp++;
        if ({val, top, top_pulse} !== {4'd0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_release: val=%0d top=%b pulse=%b, required val=0 top=0 pulse=0", val, top, top_pulse);
        end
    endtask

    task automatic test_sparse();
        int pulses = 0;
        logic [3:0] ev;
        max = 4'd7;
        for (int i = 0; i < 16; i++) begin
            en = (i % 2 == 0);
            tick();
            ev = 4'((i / 2 + 1) % 8);
            n_cmp++;
            if ({val, top, top_pulse} !== {ev, ev == 4'd7, ev == 4'd7 && i % 2 == 0}) begin
                n_bad++;
                $display("FAIL sparse i=%0d: val=%0d top=%b pulse=%b, required val=%0d top=%b pulse=%b", i, val, top, top_pulse, ev, ev == 4'd7, ev == 4'd7 && i % 2 == 0);
            end
            pulses += int'(top_pulse);
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_bad++;
            $display("FAIL sparse_pulse_count: got %0d, required 1", pulses);
        end
        en = 1'b0;
    endtask

    task automatic test_max_change();
        max = 4'd7; en = 1'b1;
        repeat (6) tick();
        n_cmp++;
        if (val !== 4'd6) begin
            n_bad++;
            $display("FAIL maxchg_reach6: val=%0d, required 6", val);
        end
        max = 4'd3;
        #1;
        n_cmp++;
        if ({top, top_pulse} !== 2'b00) begin
            n_bad++;
            $display("FAIL maxchg_top_low: top=%b pulse=%b, required 0 0", top, top_pulse);
        end
        tick();
        n_cmp++;
        if (val !== 4'd0) begin
            n_bad++;
            $display("FAIL maxchg_wrap: val=%0d, required 0", val);
        end
        repeat (3) tick();
        n_cmp++;
        if ({val, top, top_pulse} !== {4'd3, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL maxchg_top3: val=%0d top=%b pulse=%b, required val=3 top=1 pulse=1", val, top, top_pulse);
        end
        en = 1'b0;
        tick();
        n_cmp++;
        if ({val, top, top_pulse} !== {4'd3, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL maxchg_dwell: val=%0d top=%b pulse=%b, required val=3 top=1 pulse=0", val, top, top_pulse);
        end
    endtask

    task automatic test_max_zero();
        max = 4'd0; en = 1'b1; reset = 1'b0;
        tick();
        n_cmp++;
        if ({val, top, top_pulse} !== {4'd0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL max0_in_reset: val=%0d top=%b pulse=%b, required val=0 top=1 pulse=0", val, top, top_pulse);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({val, top, top_pulse} !== {4'd0, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL max0_first_pulse: val=%0d top=%b pulse=%b, required val=0 top=1 pulse=1", val, top, top_pulse);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({val, top, top_pulse} !== {4'd0, 1'b1, 1'b0}) begin
                n_bad++;
                $display("FAIL max0_steady cyc%0d: val=%0d top=%b pulse=%b, required val=0 top=1 pulse=0", i, val, top, top_pulse);
            end
        end
    endtask

    task automatic test_max_full();
        logic [3:0] ev;
        max = 4'd15; en = 1'b0; reset = 1'b0;
        tick();
        reset = 1'b1; en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick();
            ev = 4'((i + 1) % 16);
            n_cmp++;
            if ({val, top, top_pulse} !== {ev, ev == 4'd15, ev == 4'd15}) begin
                n_bad++;
                $display("FAIL full i=%0d: val=%0d top=%b pulse=%b, required val=%0d top=%b pulse=%b", i, val, top, top_pulse, ev, ev == 4'd15, ev == 4'd15);
            end
        end
    endtask

    task automatic test_mid_reset();
        max = 4'd7; en = 1'b0; reset = 1'b0;
        tick();
        reset = 1'b1; en = 1'b1;
        repeat (5) tick();
        n_cmp++;
        if (val !== 4'd5) begin
            n_bad++;
            $display("FAIL midrst_reach5: val=%0d, required 5", val);
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if ({val, top_pulse} !== {4'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL midrst_clear: val=%0d pulse=%b, required val=0 pulse=0", val, top_pulse);
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if (val !== 4'd1) begin
            n_bad++;
            $display("FAIL midrst_resume: val=%0d, required 1", val);
        end
        repeat (6) tick();
        n_cmp++;
        if ({val, top, top_pulse} !== {4'd7, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL midrst_next_top: val=%0d top=%b pulse=%b, required val=7 top=1 pulse=1", val, top, top_pulse);
        end
    endtask

    initial begin
        test_reset();
        test_sparse();
        test_max_change();
        test_max_zero();
        test_max_full();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
